// File: rtl/ddr_read_uart_sequencer.sv
// ddr_read_uart_sequencer: fetches DDR read beats and streams each one bytewise, LSB byte first, to a UART TX
module ddr_read_uart_sequencer #(
  parameter int DATA_W = 256,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic [LEN_W-1:0]  i_len,
  input  logic              i_abort,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_rd_req,
  input  logic              i_rd_valid,
  input  logic [DATA_W-1:0] i_rd_data,
  output logic [7:0]        o_tx_data,
  output logic              o_tx_start,
  input  logic              i_tx_busy,
  output logic [LEN_W-1:0]  o_beat_cnt,
  output logic [4:0]        o_byte_idx
);
  typedef enum logic [2:0] {IDLE, REQ, SEND, HOLD, WAIT, DONE} state_t;
  state_t              state_q, state_d;
  logic [DATA_W-1:0]   buf_q, buf_d;
  logic [LEN_W-1:0]    len_q, len_d, cnt_q, cnt_d;
  logic [4:0]          idx_q, idx_d;
  logic [7:0]          tx_data_q, tx_data_d;
  logic                rd_req_q, rd_req_d, tx_start_q, tx_start_d, done_q, done_d;
  // request/serialize schedule; abort overrides every state and start/done/tx pulses default low
  always_comb begin
    state_d    = state_q;
    buf_d      = buf_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    tx_data_d  = tx_data_q;
    rd_req_d   = rd_req_q;
    tx_start_d = 1'b0;
    done_d     = 1'b0;
    if (i_abort) begin
      state_d  = IDLE;
      rd_req_d = 1'b0;
      idx_d    = '0;
      cnt_d    = '0;
    end else begin
      case (state_q)
        IDLE: if (i_start) begin
          if (i_len != '0) begin
            len_d    = i_len;
            idx_d    = '0;
            cnt_d    = '0;
            rd_req_d = 1'b1;
            state_d  = REQ;
          end else state_d = DONE;
        end
        REQ: if (i_rd_valid) begin
          buf_d    = i_rd_data;
          rd_req_d = 1'b0;
          state_d  = SEND;
        end
        SEND: if (!i_tx_busy) begin
          tx_data_d  = buf_q[{idx_q, 3'b000} +: 8];
          tx_start_d = 1'b1;
          state_d    = HOLD;
        end
        HOLD: state_d = WAIT;
        WAIT: if (!i_tx_busy) begin
          if (idx_q != 5'd31) begin
            idx_d   = idx_q + 5'd1;
            state_d = SEND;
          end else begin
            cnt_d = cnt_q + LEN_W'(1);
            if (cnt_q + LEN_W'(1) == len_q) state_d = DONE;
            else begin
              idx_d    = '0;
              rd_req_d = 1'b1;
              state_d  = REQ;
            end
          end
        end
        DONE: begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  // state and datapath registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      buf_q      <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      idx_q      <= '0;
      tx_data_q  <= '0;
      rd_req_q   <= 1'b0;
      tx_start_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      buf_q      <= buf_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      tx_data_q  <= tx_data_d;
      rd_req_q   <= rd_req_d;
      tx_start_q <= tx_start_d;
      done_q     <= done_d;
    end
  end
  assign o_busy     = state_q != IDLE;
  assign o_done     = done_q;
  assign o_rd_req   = rd_req_q;
  assign o_tx_data  = tx_data_q;
  assign o_tx_start = tx_start_q;
  assign o_beat_cnt = cnt_q;
  assign o_byte_idx = idx_q;
endmodule

// File: tb/tb_ddr_read_uart_sequencer.sv
// tb_ddr_read_uart_sequencer: directed jobs against a byte-stream model with read-path and UART responders
module tb_ddr_read_uart_sequencer;
  logic         clk, rst, i_start, i_abort, i_rd_valid, i_tx_busy;
  logic [7:0]   i_len;
  logic [255:0] i_rd_data;
  logic         o_busy, o_done, o_rd_req, o_tx_start;
  logic [7:0]   o_tx_data, o_beat_cnt;
  logic [4:0]   o_byte_idx;

  ddr_read_uart_sequencer #(.DATA_W(256), .LEN_W(8)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_len(i_len), .i_abort(i_abort),
    .o_busy(o_busy), .o_done(o_done), .o_rd_req(o_rd_req), .i_rd_valid(i_rd_valid),
    .i_rd_data(i_rd_data), .o_tx_data(o_tx_data), .o_tx_start(o_tx_start),
    .i_tx_busy(i_tx_busy), .o_beat_cnt(o_beat_cnt), .o_byte_idx(o_byte_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  int cyc = 0, job_id = 0, seen_job = 0, job_len = 0;
  int sent = 0, reqs = 0, dones = 0, beat_n = 0, wcnt = 0, ucnt = 0;
  int busy_len = 0, spur_at = -1, spur_cd = 0, last_tx = -10;
  int dly [3];
  bit req_seen = 0, prev_tx = 0, prev_done = 0, spur_hit = 0;
  logic [7:0] pat = 8'h00;
  logic [7:0] got [8192];
  logic [7:0] exp_q [$];

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [255:0] beat_data(input int b, input logic [7:0] p);
    logic [255:0] d;
    for (int k = 0; k < 32; k++) d[8*k +: 8] = 8'(b*32 + k) ^ p;
    return d;
  endfunction

  task automatic monitor();
    forever begin
      @(negedge clk);
      cyc++;
      if (job_id != seen_job) begin
        seen_job = job_id;
        exp_q.delete();
        sent = 0; reqs = 0; dones = 0; beat_n = 0; req_seen = 0;
        spur_cd = 0; spur_hit = 0; last_tx = -10;
      end
      if (i_rd_valid) begin
        i_rd_valid = 1'b0;
        req_seen = 0;
      end else if (o_rd_req) begin
        if (!req_seen) begin
          req_seen = 1;
          reqs++;
          wcnt = beat_n < 3 ? dly[beat_n] : 0;
        end
        if (wcnt == 0) begin
          i_rd_data = beat_data(beat_n, pat);
          i_rd_valid = 1'b1;
          for (int k = 0; k < 32; k++) exp_q.push_back(8'(beat_n*32 + k) ^ pat);
          beat_n++;
        end else wcnt--;
      end
      if (spur_cd > 0) begin
        spur_cd--;
        if (spur_cd == 0) begin
          i_rd_valid = 1'b1;
          i_rd_data = {32{8'hA5}};
          spur_hit = 1;
        end
      end
      if (o_tx_start) ucnt = busy_len;
      else if (ucnt > 0) ucnt--;
      i_tx_busy = ucnt > 0;
      if (o_tx_start) begin
        chk("tx_back_to_back", prev_tx, 0);
        chk("tx_during_req", o_rd_req, 0);
        chk("tx_spacing_ge3", (cyc - last_tx) >= 3, 1);
        chk("tx_byte_idx", o_byte_idx, sent % 32);
        chk("tx_beat_cnt", o_beat_cnt, sent / 32);
        if (exp_q.size() == 0) chk("tx_unexpected", 1, 0);
        else chk("tx_data", o_tx_data, exp_q.pop_front());
        if (sent < 8192) got[sent] = o_tx_data;
        if (sent == spur_at) spur_cd = 2;
        sent++;
        last_tx = cyc;
      end
      prev_tx = o_tx_start;
      if (o_done) begin
        dones++;
        chk("done_one_cycle", prev_done, 0);
        if (job_len != 0) begin
          chk("done_beat_cnt", o_beat_cnt, job_len);
          chk("done_all_bytes_sent", exp_q.size(), 0);
        end
      end
      prev_done = o_done;
      if (o_busy && job_len != 0) chk("beat_cnt_le_len", o_beat_cnt <= 8'(job_len), 1);
    end
  endtask

  task automatic setup(input logic [7:0] p, input int bl, input int d0, input int d1, input int d2, input int sa);
    pat = p; busy_len = bl; dly[0] = d0; dly[1] = d1; dly[2] = d2; spur_at = sa;
  endtask

  task automatic run_start(input int len);
    job_id++;
    job_len = len;
    @(posedge clk); #1 i_start = 1'b1; i_len = 8'(len);
    @(posedge clk); #1 i_start = 1'b0; i_len = 8'hEE;
    @(negedge clk);
    chk("start_busy", o_busy, 1);
    chk("start_rd_req", o_rd_req, len != 0);
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      if (dones != 0) break;
    end
    chk("done_within_budget", dones != 0, 1);
    @(negedge clk);
  endtask

  task automatic wait_sent(input int n, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      if (sent >= n) break;
    end
    chk("reach_byte_count", sent >= n, 1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_done"}, o_done, 0);
    chk({tag, "_rd_req"}, o_rd_req, 0);
    chk({tag, "_tx_data"}, o_tx_data, 0);
    chk({tag, "_tx_start"}, o_tx_start, 0);
    chk({tag, "_beat_cnt"}, o_beat_cnt, 0);
    chk({tag, "_byte_idx"}, o_byte_idx, 0);
  endtask

  initial begin
    rst = 1'b1; i_start = 1'b0; i_abort = 1'b0; i_len = 8'h00;
    i_rd_valid = 1'b0; i_rd_data = '0; i_tx_busy = 1'b0;
    dly[0] = 0; dly[1] = 0; dly[2] = 0;
    fork monitor(); join_none
    #7 chk_all_zero("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    setup(8'h3C, 2, 0, 0, 0, -1);
    run_start(2);
    wait_sent(11, 2000);
    @(negedge clk); #2 rst = 1'b1;
    #1 chk_all_zero("async_reset");
    #10 rst = 1'b0;
    @(negedge clk);

    setup(8'h00, 4, 0, 0, 0, -1);
    run_start(1);
    wait_done(3000);
    repeat (5) @(posedge clk);
    chk("len1_rd_reqs", reqs, 1);
    chk("len1_tx_count", sent, 32);
    chk("len1_done_count", dones, 1);
    chk("len1_beat_cnt", o_beat_cnt, 1);
    chk("len1_first_byte", got[0], 8'h00);
    chk("len1_byte17", got[17], 8'h11);
    chk("len1_last_byte", got[31], 8'h1F);

    setup(8'h5A, 0, 0, 5, 20, 5);
    run_start(3);
    wait_sent(40, 2000);
    #1 i_start = 1'b1; i_len = 8'd1;
    @(posedge clk); #1 i_start = 1'b0;
    wait_done(5000);
    repeat (10) @(posedge clk);
    chk("len3_rd_reqs", reqs, 3);
    chk("len3_tx_count", sent, 96);
    chk("len3_done_count", dones, 1);
    chk("len3_idle_after", o_busy, 0);
    chk("len3_spurious_injected", spur_hit, 1);
    chk("len3_byte5", got[5], 8'h5F);
    chk("len3_byte6_after_spurious", got[6], 8'h5C);
    chk("len3_last_byte", got[95], 8'h05);

    setup(8'h00, 0, 0, 0, 0, -1);
    run_start(0);
    chk("len0_done_early", o_done, 0);
    @(negedge clk);
    chk("len0_done_pulse", o_done, 1);
    chk("len0_idle_at_done", o_busy, 0);
    repeat (5) @(posedge clk);
    chk("len0_rd_reqs", reqs, 0);
    chk("len0_tx_count", sent, 0);
    chk("len0_done_count", dones, 1);

    setup(8'h11, 4, 3, 3, 0, -1);
    run_start(2);
    wait_sent(50, 4000);
    #1 i_abort = 1'b1;
    @(posedge clk); #1 i_abort = 1'b0;
    @(negedge clk);
    chk("abort_busy", o_busy, 0);
    chk("abort_rd_req", o_rd_req, 0);
    chk("abort_tx_start", o_tx_start, 0);
    chk("abort_byte_idx", o_byte_idx, 0);
    chk("abort_beat_cnt", o_beat_cnt, 0);
    repeat (30) @(posedge clk);
    chk("abort_no_more_tx", sent, 50);
    chk("abort_no_done", dones, 0);
    #1 i_abort = 1'b1; i_start = 1'b1; i_len = 8'd1;
    @(posedge clk); #1 i_abort = 1'b0; i_start = 1'b0;
    @(negedge clk);
    chk("abort_beats_start_busy", o_busy, 0);
    chk("abort_beats_start_rd_req", o_rd_req, 0);

    setup(8'h00, 0, 0, 0, 0, -1);
    run_start(255);
    wait_done(40000);
    chk("len255_rd_reqs", reqs, 255);
    chk("len255_tx_count", sent, 8160);
    chk("len255_beat_cnt", o_beat_cnt, 255);
    chk("len255_last_byte", got[8159], 8'hDF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ddr_read_uart_sequencer.md
# ddr_read_uart_sequencer

- Reads a requested number of 256-bit DDR read beats from the read path, one beat at a time.
- Serializes each beat into 32 bytes for the UART transmitter, byte 0 (bits [7:0]) first.
- Sits between the AXI read-data capture logic and the UART TX, and replaces free-running byte selection with an explicit request/ack schedule.
- Reports busy, progress and completion to the command decoder.

## Interface
Parameters:
- DATA_W, 256, read beat width; fixed at 256 (32 bytes per beat)
- LEN_W, 8, width of the beat-count field

Ports:
- clk  in  1  single clock for all logic
- rst  in  1  asynchronous, active-high reset
- i_start  in  1  start pulse; sampled only in IDLE
- i_len  in  LEN_W  number of beats to send; latched on accepted start
- i_abort  in  1  synchronous abort; highest priority after rst
- o_busy  out  1  high whenever state != IDLE
- o_done  out  1  one-cycle completion pulse
- o_rd_req  out  1  request for next beat; held until i_rd_valid
- i_rd_valid  in  1  read beat present on i_rd_data
- i_rd_data  in  DATA_W  read beat
- o_tx_data  out  8  byte to UART TX
- o_tx_start  out  1  one-cycle TX start pulse
- i_tx_busy  in  1  UART TX busy; must rise no later than one cycle after o_tx_start
- o_beat_cnt  out  LEN_W  beats fully sent in current job
- o_byte_idx  out  5  index of current byte within beat

## Operation
**States:** IDLE, REQ, SEND, HOLD, WAIT, DONE.

**Registers**
- 256-bit beat buffer.
- Latched length len_q.
- Byte index idx (5 bits).
- Beat counter.

**Transitions**
- IDLE:
  - i_start with i_len != 0: latch len_q, clear idx and beat count, set o_rd_req=1, go to REQ.
  - i_start with i_len == 0: go to DONE (no read, no TX).
- REQ:
  - Waits for i_rd_valid.
  - On i_rd_valid: capture i_rd_data into the buffer, clear o_rd_req, go to SEND.
- SEND:
  - Waits for i_tx_busy == 0.
  - Then: o_tx_data <= buffer[8*idx+7 : 8*idx], o_tx_start <= 1, go to HOLD.
- HOLD:
  - o_tx_start <= 0, go to WAIT.
  - i_tx_busy is ignored in this state.
- WAIT:
  - Waits for i_tx_busy == 0.
  - idx != 31: idx <= idx+1, go to SEND.
  - idx == 31 and beat_cnt+1 == len_q: beat_cnt <= beat_cnt+1, go to DONE.
  - idx == 31 otherwise: beat_cnt <= beat_cnt+1, idx <= 0, o_rd_req <= 1, go to REQ.
- DONE: o_done <= 1 for one cycle, go to IDLE.

**Input handling**
- i_rd_valid outside REQ is ignored; the buffer is unchanged.
- i_start outside IDLE is ignored. i_len changes after start have no effect.
- i_abort in any state: go to IDLE next edge with o_rd_req=0, o_tx_start=0, no o_done; idx and beat_cnt are cleared. A byte already started on the UART completes on its own.
- i_abort and i_start in the same IDLE cycle: abort wins; the start is dropped.

**Arithmetic**
- idx wraps 31→0 only through the beat-completion path.
- beat_cnt never exceeds len_q.
- len_q = 255 sends 255 beats (8160 bytes).

## Timing
**Reset values:** all outputs 0 (o_busy, o_done, o_rd_req, o_tx_data, o_tx_start, o_beat_cnt, o_byte_idx); state IDLE; buffer 0.

**Latencies**
- i_start accepted on edge N: o_rd_req and o_busy high after edge N.
- i_rd_valid seen on edge M: o_rd_req low after M. Earliest o_tx_start for byte 0 is high after edge M+1.
- Byte spacing with an idle UART is at least 3 cycles (SEND→HOLD→WAIT→SEND).
- Last byte's busy falls at edge K: o_done is high for the cycle after edge K+1, then o_busy falls.

**Signal rules**
- o_tx_data is stable from the o_tx_start pulse until the next pulse.
- o_tx_start is never high for two consecutive cycles.
- Async rst mid-job clears all outputs immediately.

## Test plan
- Reset mid-transfer (after byte 10 of beat 0): all outputs go to 0 asynchronously. A following i_start with i_len=1 runs normally from byte 0.
- i_len=1, beat = bytes 0x00..0x1F ascending, UART busy 4 cycles per byte:
  - o_rd_req pulses once.
  - 32 tx_start pulses carry 0x00..0x1F in order.
  - o_done fires once; o_beat_cnt=1.
- i_len=3 with i_rd_valid delayed 0, 5 and 20 cycles after each o_rd_req:
  - Exactly 3 requests, 96 bytes in order.
  - No TX pulse while in REQ.
- i_len=0: o_done pulses 2 cycles after i_start; no o_rd_req, no o_tx_start.
- Spurious stimulus:
  - i_rd_valid while in SEND: buffer is unchanged.
  - i_start during a transfer: ignored, job length unchanged.
- i_abort during WAIT of byte 17, beat 1 of 2: IDLE next cycle, o_busy=0, no o_done, no further tx_start.
